// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared bus constants, DMA state enum and source-address helper
package gb_bus_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam int          OAM_LEN      = 160;
    localparam logic [7:0]  OAM_LAST     = 8'(OAM_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_e;

    // Pages 0xE0-0xFF alias down onto work RAM, as echo RAM does.
    function automatic logic [7:0] dma_src_base(input logic [7:0] src_hi);
        return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - OAM DMA state machine, index counter, source register and OAM write pipeline
module oam_dma_engine
    import gb_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wr,
    input  logic [7:0]  reg_wdata,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  src_hi,
    output logic        dma_active,
    output logic        dma_rd,
    output logic [15:0] dma_addr,
    output logic        oam_write,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data
);

    dma_state_e  state_q, state_d;
    logic [1:0]  t_cycle_q, t_cycle_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic        start_blk_q, start_blk_d;
    logic        oam_write_q, oam_write_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  oam_data_q, oam_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            t_cycle_q   <= 2'd0;
            index_q     <= 8'd0;
            src_hi_q    <= 8'd0;
            start_blk_q <= 1'b0;
            oam_write_q <= 1'b0;
            oam_addr_q  <= 8'd0;
            oam_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            t_cycle_q   <= t_cycle_d;
            index_q     <= index_d;
            src_hi_q    <= src_hi_d;
            start_blk_q <= start_blk_d;
            oam_write_q <= oam_write_d;
            oam_addr_q  <= oam_addr_d;
            oam_data_q  <= oam_data_d;
        end
    end

    always_comb begin
        t_cycle_d   = t_cycle_q + 2'd1;
        state_d     = state_q;
        index_d     = index_q;
        src_hi_d    = src_hi_q;
        start_blk_d = start_blk_q;
        oam_write_d = 1'b0;
        oam_addr_d  = oam_addr_q;
        oam_data_d  = oam_data_q;
        if (t_cycle_q == 2'd3) begin
            case (state_q)
                START: begin
                    state_d     = XFER;
                    start_blk_d = 1'b0;
                end
                XFER: begin
                    // The byte read this M-cycle is committed even if a restart lands now.
                    oam_write_d = 1'b1;
                    oam_addr_d  = index_q;
                    oam_data_d  = bus_data_in;
                    if (index_q == OAM_LAST) begin
                        state_d = IDLE;
                        index_d = 8'd0;
                    end else begin
                        index_d = index_q + 8'd1;
                    end
                end
                default: ;
            endcase
            if (reg_wr) begin
                src_hi_d    = reg_wdata;
                state_d     = START;
                index_d     = 8'd0;
                start_blk_d = dma_active;
            end
        end
    end

    always_comb begin
        dma_active = (state_q == XFER) || ((state_q == START) && start_blk_q);
        dma_rd     = (state_q == XFER);
        dma_addr   = {dma_src_base(src_hi_q), index_q};
        src_hi     = src_hi_q;
        oam_write  = oam_write_q;
        oam_addr   = oam_addr_q;
        oam_data   = oam_data_q;
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - CPU/DMA/HRAM bus arbiter with OAM DMA; OAM_DMA_BUS_CONFLICT_EN returns the DMA byte on blocked reads
module oam_dma_arbiter
    import gb_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        hram_enable,
    output logic        hram_write,
    output logic [6:0]  hram_addr,
    output logic [7:0]  hram_data_out,
    input  logic [7:0]  hram_data_in,
    output logic        oam_write,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        dma_active
);

    logic        is_dma_reg;
    logic        is_hram;
    logic        reg_wr;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  src_hi;
    logic [7:0]  blocked_rdata;

    oam_dma_engine u_engine (
        .clk         (clk),
        .reset       (reset),
        .reg_wr      (reg_wr),
        .reg_wdata   (cpu_data_out),
        .bus_data_in (bus_data_in),
        .src_hi      (src_hi),
        .dma_active  (dma_active),
        .dma_rd      (dma_rd),
        .dma_addr    (dma_addr),
        .oam_write   (oam_write),
        .oam_addr    (oam_addr),
        .oam_data    (oam_data)
    );

`ifdef OAM_DMA_BUS_CONFLICT_EN
    assign blocked_rdata = bus_data_in;
`else
    assign blocked_rdata = 8'hFF;
`endif

    always_comb begin
        is_dma_reg    = (cpu_addr == DMA_REG_ADDR);
        is_hram       = (cpu_addr >= HRAM_BASE) && (cpu_addr != 16'hFFFF);
        reg_wr        = cpu_enable && cpu_write && is_dma_reg;

        hram_enable   = cpu_enable && is_hram;
        hram_write    = hram_enable && cpu_write;
        hram_addr     = hram_enable ? cpu_addr[6:0] : 7'd0;
        hram_data_out = hram_write ? cpu_data_out : 8'd0;

        if (dma_active) begin
            bus_addr     = dma_addr;
            bus_enable   = dma_rd;
            bus_write    = 1'b0;
            bus_data_out = 8'd0;
        end else begin
            bus_addr     = cpu_addr;
            bus_enable   = cpu_enable && !is_dma_reg && !is_hram;
            bus_write    = bus_enable && cpu_write;
            bus_data_out = bus_write ? cpu_data_out : 8'd0;
        end

        if (is_dma_reg) begin
            cpu_data_in = src_hi;
        end else if (is_hram) begin
            cpu_data_in = hram_data_in;
        end else if (dma_active) begin
            cpu_data_in = blocked_rdata;
        end else begin
            cpu_data_in = bus_data_in;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - directed self-checking bench for oam_dma_arbiter
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_enable;
    logic        cpu_write;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;
    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        hram_enable;
    logic        hram_write;
    logic [6:0]  hram_addr;
    logic [7:0]  hram_data_out;
    logic [7:0]  hram_data_in;
    logic        oam_write;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        dma_active;

    int checks = 0;
    int errors = 0;
    int active_cnt = 0;
    int pulse_cnt = 0;
    int buswr_cnt = 0;
    int active_base, pulse_base, buswr_base;
    logic [1:0] tb_t;
    logic [7:0] oam_mem [0:255];
    logic [15:0] exp16;

    always #5 clk = ~clk;

    oam_dma_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_enable    (cpu_enable),
        .cpu_write     (cpu_write),
        .cpu_data_out  (cpu_data_out),
        .cpu_data_in   (cpu_data_in),
        .bus_addr      (bus_addr),
        .bus_enable    (bus_enable),
        .bus_write     (bus_write),
        .bus_data_out  (bus_data_out),
        .bus_data_in   (bus_data_in),
        .hram_enable   (hram_enable),
        .hram_write    (hram_write),
        .hram_addr     (hram_addr),
        .hram_data_out (hram_data_out),
        .hram_data_in  (hram_data_in),
        .oam_write     (oam_write),
        .oam_addr      (oam_addr),
        .oam_data      (oam_data),
        .dma_active    (dma_active)
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a[15:8] == 8'hC1) ? (a[7:0] ^ 8'h5A) : (a[7:0] ^ a[15:8]);
    endfunction

    assign bus_data_in  = mem_byte(bus_addr);
    assign hram_data_in = 8'h3C;

    always @(negedge clk) begin
        if (dma_active) active_cnt++;
        if (bus_write) buswr_cnt++;
        if (oam_write) begin
            pulse_cnt++;
            oam_mem[oam_addr] = oam_data;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tb_t = tb_t + 2'd1;
        end
    endtask

    task automatic cpu_idle();
        cpu_addr = 16'h0000; cpu_enable = 1'b0; cpu_write = 1'b0; cpu_data_out = 8'h00;
        #1;
    endtask

    task automatic cpu_set(input logic [15:0] a, input logic wr, input logic [7:0] d);
        cpu_addr = a; cpu_enable = 1'b1; cpu_write = wr; cpu_data_out = d;
        #1;
    endtask

    // Holds a 0xFF46 write for a whole M-cycle; returns at t_cycle 0 of the START M-cycle.
    task automatic write_dma(input logic [7:0] v);
        while (tb_t != 2'd0) tick(1);
        cpu_set(16'hFF46, 1'b1, v);
        tick(4);
        cpu_idle();
    endtask

    task automatic snap();
        active_base = active_cnt; pulse_base = pulse_cnt; buswr_base = buswr_cnt;
    endtask

    initial begin
        tb_t = 2'd0;
        reset = 1'b1;
        cpu_idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        tb_t = 2'd0;

        check("rst_dma_active", 16'(dma_active), 16'h0);
        check("rst_oam_write", 16'(oam_write), 16'h0);
        check("rst_oam_addr", 16'(oam_addr), 16'h0);
        check("rst_oam_data", 16'(oam_data), 16'h0);
        check("rst_bus_write", 16'(bus_write), 16'h0);
        check("rst_hram_enable", 16'(hram_enable), 16'h0);
        cpu_set(16'hFF46, 1'b0, 8'h00);
        check("rst_reg_read", 16'(cpu_data_in), 16'h00);
        check("reg_read_no_bus", 16'(bus_enable), 16'h0);
        cpu_set(16'h8000, 1'b0, 8'h00);
        check("idle_cpu_bus_addr", bus_addr, 16'h8000);
        check("idle_cpu_read", 16'(cpu_data_in), 16'(mem_byte(16'h8000)));
        cpu_idle();

        // Full transfer from page C1 with CPU traffic in the middle.
        write_dma(8'hC1);
        snap();
        check("c1_start_not_active", 16'(dma_active), 16'h0);
        tick(4);
        check("c1_active_rise", 16'(dma_active), 16'h1);
        check("c1_first_addr", bus_addr, 16'hC100);
        check("c1_first_enable", 16'(bus_enable), 16'h1);
        tick(40);
        cpu_set(16'h8000, 1'b0, 8'h00);
`ifdef OAM_DMA_BUS_CONFLICT_EN
        exp16 = 16'(mem_byte(16'hC10A));
`else
        exp16 = 16'h00FF;
`endif
        check("blocked_read", 16'(cpu_data_in), exp16);
        check("blocked_read_addr", bus_addr, 16'hC10A);
        cpu_set(16'h8000, 1'b1, 8'hAA);
        check("blocked_write_dropped", 16'(bus_write), 16'h0);
        check("blocked_write_addr", bus_addr, 16'hC10A);
        tick(1);
        cpu_set(16'hFF90, 1'b0, 8'h00);
        check("hram_read_data", 16'(cpu_data_in), 16'h3C);
        check("hram_read_en", 16'(hram_enable), 16'h1);
        check("hram_read_addr", 16'(hram_addr), 16'h10);
        cpu_set(16'hFF90, 1'b1, 8'h77);
        check("hram_write_en", 16'(hram_write), 16'h1);
        check("hram_write_data", 16'(hram_data_out), 16'h77);
        tick(1);
        cpu_set(16'hFF46, 1'b0, 8'h00);
        check("reg_read_during_xfer", 16'(cpu_data_in), 16'hC1);
        check("reg_read_bus_owned", bus_addr, 16'hC10A);
        tick(1);
        cpu_idle();
        tick(1);
        tick(596);
        check("c1_active_fall", 16'(dma_active), 16'h0);
        check("c1_last_pulse", 16'(oam_write), 16'h1);
        check("c1_last_addr", 16'(oam_addr), 16'd159);
        check("c1_last_data", 16'(oam_data), 16'(8'd159 ^ 8'h5A));
        tick(1);
        check("c1_pulse_end", 16'(oam_write), 16'h0);
        check("c1_pulse_count", 16'(pulse_cnt - pulse_base), 16'd160);
        check("c1_active_clks", 16'(active_cnt - active_base), 16'd640);
        check("c1_cpu_bus_writes", 16'(buswr_cnt - buswr_base), 16'd0);
        for (int i = 0; i < 160; i++)
            check($sformatf("c1_oam_%0d", i), 16'(oam_mem[i]), 16'(8'(i) ^ 8'h5A));

        // Echo-RAM source page.
        write_dma(8'hFE);
        tick(4);
        check("fe_first_addr", bus_addr, 16'hDE00);
        tick(4 * 159);
        check("fe_last_addr", bus_addr, 16'hDE9F);
        tick(4);
        check("fe_active_fall", 16'(dma_active), 16'h0);
        check("fe_last_data", 16'(oam_data), 16'(8'h9F ^ 8'hDE));

        // Restart with page C2 during the M-cycle reading index 80.
        write_dma(8'hC1);
        tick(4);
        tick(4 * 80);
        check("rs_byte79_pulse", 16'(oam_write), 16'h1);
        check("rs_byte79_addr", 16'(oam_addr), 16'd79);
        check("rs_byte79_data", 16'(oam_data), 16'(8'd79 ^ 8'h5A));
        check("rs_index80_addr", bus_addr, 16'hC150);
        write_dma(8'hC2);
        check("rs_start_active", 16'(dma_active), 16'h1);
        tick(1);
        snap();
        tick(3);
        check("rs_first_addr", bus_addr, 16'hC200);
        check("rs_xfer_active", 16'(dma_active), 16'h1);
        tick(640);
        check("rs_active_fall", 16'(dma_active), 16'h0);
        check("rs_last_data", 16'(oam_data), 16'(8'd159 ^ 8'hC2));
        tick(1);
        check("rs_pulse_count", 16'(pulse_cnt - pulse_base), 16'd160);
        check("rs_oam_0", 16'(oam_mem[0]), 16'(8'h00 ^ 8'hC2));
        check("rs_oam_100", 16'(oam_mem[100]), 16'(8'd100 ^ 8'hC2));

        // Reset mid-transfer.
        write_dma(8'hC1);
        tick(4 + 4 * 40 + 2);
        check("rt_active_before", 16'(dma_active), 16'h1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tb_t = 2'd0;
        check("rt_active_dropped", 16'(dma_active), 16'h0);
        check("rt_no_pulse", 16'(oam_write), 16'h0);
        snap();
        tick(12);
        check("rt_no_more_pulses", 16'(pulse_cnt - pulse_base), 16'd0);
        cpu_set(16'hFF46, 1'b0, 8'h00);
        check("rt_reg_cleared", 16'(cpu_data_in), 16'h00);
        cpu_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
